// File: rtl/led7seg_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver: segment bit positions,
// digit count, the hex font and the captured display-configuration record.
package led7seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Glyphs stored as {g,f,e,d,c,b,a}; entry 15 first so FONT_TABLE[n] is glyph n.
  localparam logic [15:0][6:0] FONT_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_suppress;
  } disp_cfg_t;

endpackage

// File: rtl/led7seg_scan_if.sv
// Host-side bundle of the scan driver: display data/load strobe in, LED/SA/frame_tick out.
interface led7seg_scan_if;

  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_suppress;
  logic        load;
  logic [7:0]  LED;
  logic [3:0]  SA;
  logic        frame_tick;

  modport master (
    output value, dp, blank, lz_suppress, load,
    input  LED, SA, frame_tick
  );

  modport slave (
    input  value, dp, blank, lz_suppress, load,
    output LED, SA, frame_tick
  );

endinterface

// File: rtl/seg_font.sv
// Combinational hex nibble to 7-segment glyph decoder; output bits follow the LED bit layout.
module seg_font
  import led7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = FONT_TABLE[nibble_i];
    seg_o = '0;
    seg_o[SEG_A] = glyph[0];
    seg_o[SEG_B] = glyph[1];
    seg_o[SEG_C] = glyph[2];
    seg_o[SEG_D] = glyph[3];
    seg_o[SEG_E] = glyph[4];
    seg_o[SEG_F] = glyph[5];
    seg_o[SEG_G] = glyph[6];
  end

endmodule

// File: rtl/led7seg_scan.sv
// Four-digit round-robin 7-segment scanner with frame-aligned (tear-free) updates,
// per-slot anti-ghosting blank, leading-zero suppression and registered LED/SA outputs.
module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input logic           clk,
  input logic           rst,
  led7seg_scan_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);
  localparam logic [1:0]      DigMax   = 2'(NUM_DIGITS - 1);
  localparam logic [7:0]      LedOff   = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]      SaOff    = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  disp_cfg_t       pend_q, pend_d;
  disp_cfg_t       act_q, act_d;
  logic [7:0]      led_q, led_d;
  logic [3:0]      sa_q, sa_d;

  disp_cfg_t       in_cfg;
  logic            slot_wrap;
  logic            frame_tick;
  logic [3:0]      nibble;
  logic [6:0]      glyph;
  logic [3:0]      suppressed;
  logic            zero_run;
  logic            dark;
  logic [7:0]      led_raw;
  logic [3:0]      sa_raw;

  always_comb begin
    in_cfg.value       = bus.value;
    in_cfg.dp          = bus.dp;
    in_cfg.blank       = bus.blank;
    in_cfg.lz_suppress = bus.lz_suppress;
  end

  assign slot_wrap  = (cnt_q == CntMax);
  assign frame_tick = slot_wrap && (dig_q == DigMax);

  // Prescaler, digit index and the pending/active double buffer. A load coinciding with the
  // frame boundary goes straight to active because pend_d already carries it.
  always_comb begin
    cnt_d  = slot_wrap ? '0 : cnt_q + 1'b1;
    dig_d  = slot_wrap ? dig_q + 2'd1 : dig_q;
    pend_d = bus.load ? in_cfg : pend_q;
    act_d  = frame_tick ? pend_d : act_q;
  end

  // Digit i is suppressed when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    suppressed = '0;
    zero_run   = act_q.lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (act_q.value[4*i +: 4] == 4'h0);
      suppressed[i] = zero_run;
    end
  end

  assign nibble = 4'(act_q.value >> {dig_q, 2'b00});

  seg_font u_seg_font (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    dark    = (cnt_q < BlankEnd) || act_q.blank[dig_q] || suppressed[dig_q];
    led_raw = '0;
    sa_raw  = '0;
    if (!dark) begin
      led_raw[6:0]   = glyph;
      led_raw[SEG_DP] = act_q.dp[dig_q];
      sa_raw         = 4'b0001 << dig_q;
    end
    led_d = ACTIVE_LOW ? ~led_raw : led_raw;
    sa_d  = ACTIVE_LOW ? ~sa_raw : sa_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dig_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
      led_q  <= LedOff;
      sa_q   <= SaOff;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      led_q  <= led_d;
      sa_q   <= sa_d;
    end
  end

  assign bus.LED        = led_q;
  assign bus.SA         = sa_q;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_led7seg_scan.sv
// Bench for led7seg_scan: an active-high and an active-low instance share stimulus and are
// compared every cycle against a frame-level model, plus table vectors and corner sequences.
module tb_led7seg_scan;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;
  localparam int          PER   = 4 * DIV;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } cfg_t;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][7:0] led;
    logic [3:0][3:0] sa;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz = 1'b0;
  logic        load = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: phase = position within the frame, out_phase = phase shown on the outputs.
  int   phase = 0;
  int   out_phase = -1;
  int   frame_no = 0;
  cfg_t pend = '0;
  cfg_t act = '0;

  always #5 clk = ~clk;

  led7seg_scan_if bus_h ();
  led7seg_scan_if bus_l ();

  assign bus_h.value = value;
  assign bus_h.dp = dp;
  assign bus_h.blank = blank;
  assign bus_h.lz_suppress = lz;
  assign bus_h.load = load;
  assign bus_l.value = value;
  assign bus_l.dp = dp;
  assign bus_l.blank = blank;
  assign bus_l.lz_suppress = lz;
  assign bus_l.load = load;

  led7seg_scan #(.DIV(DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b0)) u_dut_h (
    .clk (clk),
    .rst (rst),
    .bus (bus_h)
  );

  led7seg_scan #(.DIV(DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)) u_dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Returns {SA, LED} for a given frame position and displayed configuration.
  function automatic logic [11:0] model_out(input int ph, input cfg_t a);
    int         d;
    int         c;
    logic [3:0] nib;
    bit         sup;
    d   = ph / DIV;
    c   = ph % DIV;
    nib = 4'(a.value >> (4 * d));
    sup = a.lz && (d > 0) && ((a.value >> (4 * d)) == 16'h0);
    if (c < BLANK || a.blank[d] || sup) return 12'h000;
    return {4'(1 << d), a.dp[d], font(nib)};
  endfunction

  always @(posedge clk) begin
    logic [7:0] exp_led;
    logic [3:0] exp_sa;
    logic [7:0] exp_led_l;
    logic [3:0] exp_sa_l;
    cfg_t       inw;
    inw = '{value, dp, blank, lz};
    if (rst) begin
      {exp_sa, exp_led} = 12'h000;
      pend = '0;
      act = '0;
      phase = 0;
      out_phase = -1;
    end else begin
      out_phase = phase;
      {exp_sa, exp_led} = model_out(phase, act);
      if (load) pend = inw;
      if (phase == PER - 1) begin
        act = pend;
        frame_no++;
      end
      phase = (phase + 1) % PER;
    end
    exp_led_l = ~exp_led;
    exp_sa_l  = ~exp_sa;
    #1;
    chk("cycle LED", bus_h.LED, exp_led);
    chk("cycle SA", bus_h.SA, exp_sa);
    chk("cycle LED active-low", bus_l.LED, exp_led_l);
    chk("cycle SA active-low", bus_l.SA, exp_sa_l);
    chk("cycle frame_tick", bus_h.frame_tick, phase == PER - 1);
    chk("cycle frame_tick active-low", bus_l.frame_tick, phase == PER - 1);
  end

  task automatic wait_out(input int target, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_phase != target && n < 64);
    if (out_phase != target) chk({nm, " timeout"}, 32'(out_phase), 32'(target));
  endtask

  task automatic wait_phase(input int target);
    int n = 0;
    while (phase != target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (phase != target) chk("wait_phase timeout", 32'(phase), 32'(target));
  endtask

  task automatic wait_new_frame(input int f0);
    int n = 0;
    while (frame_no <= f0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (frame_no <= f0) chk("frame timeout", 32'(frame_no), 32'(f0 + 1));
  endtask

  task automatic chk_slot(input string nm, input logic [7:0] e_led, input logic [3:0] e_sa);
    logic [7:0] e_led_l;
    logic [3:0] e_sa_l;
    e_led_l = ~e_led;
    e_sa_l  = ~e_sa;
    chk({nm, " LED"}, bus_h.LED, e_led);
    chk({nm, " SA"}, bus_h.SA, e_sa);
    chk({nm, " LED active-low"}, bus_l.LED, e_led_l);
    chk({nm, " SA active-low"}, bus_l.SA, e_sa_l);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++) if ($urandom % 2 == 1) v[4*i +: 4] = 4'($urandom);
    return v;
  endfunction

  logic [3:0] sa_seq [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                             4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
  vec_t vecs [8];

  initial begin
    int ticks;
    int f0;
    vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {8'h06, 8'h5B, 8'h77, 8'h71}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[1] = '{16'h0050, 4'h0, 4'h0, 1'b1, {8'h00, 8'h00, 8'h6D, 8'h3F}, {4'h0, 4'h0, 4'h2, 4'h1}};
    vecs[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, {8'h00, 8'h00, 8'h00, 8'h3F}, {4'h0, 4'h0, 4'h0, 4'h1}};
    vecs[3] = '{16'h8888, 4'h4, 4'h1, 1'b0, {8'h7F, 8'hFF, 8'h7F, 8'h00}, {4'h8, 4'h4, 4'h2, 4'h0}};
    vecs[4] = '{16'h4321, 4'h0, 4'h0, 1'b0, {8'h66, 8'h4F, 8'h5B, 8'h06}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[5] = '{16'hC0DE, 4'h8, 4'h0, 1'b1, {8'hB9, 8'h3F, 8'h5E, 8'h79}, {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[6] = '{16'h0100, 4'h0, 4'h0, 1'b1, {8'h00, 8'h06, 8'h3F, 8'h3F}, {4'h0, 4'h4, 4'h2, 4'h1}};
    vecs[7] = '{16'h0007, 4'hF, 4'h0, 1'b1, {8'h00, 8'h00, 8'h00, 8'h87}, {4'h0, 4'h0, 4'h0, 4'h1}};

    // Reset release: fixed SA sequence, lit slots show the zero glyph.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk_slot("reset seq", (sa_seq[k] != 4'h0) ? 8'h3F : 8'h00, sa_seq[k]);
    end
    ticks = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus_h.frame_tick) ticks++;
    end
    chk("frame_tick count in 32 cycles", 32'(ticks), 32'd2);

    // Table vectors, loaded at a random point in the frame; inputs scrambled after the strobe.
    for (int v = 0; v < 8; v++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      value = vecs[v].value;
      dp = vecs[v].dp;
      blank = vecs[v].blank;
      lz = vecs[v].lz;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      value = 16'($urandom);
      dp = 4'($urandom);
      blank = 4'($urandom);
      lz = 1'($urandom);
      f0 = frame_no;
      wait_new_frame(f0);
      for (int d = 0; d < 4; d++) begin
        wait_out(d * DIV + BLANK, "vector slot");
        chk_slot($sformatf("vec%0d digit%0d", v, d), vecs[v].led[d], vecs[v].sa[d]);
      end
    end

    // Load coinciding with frame_tick shows next frame; a later load waits a further frame.
    wait_phase(PER - 1);
    chk("frame_tick at coincident load", bus_h.frame_tick, 1'b1);
    value = 16'h4321; dp = '0; blank = '0; lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    f0 = frame_no;
    @(negedge clk);
    value = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_out(DIV + BLANK, "tick load");
    chk_slot("tick load digit1", 8'h5B, 4'h2);
    wait_out(3 * DIV + BLANK, "tick load");
    chk_slot("tick load digit3", 8'h66, 4'h8);
    wait_new_frame(f0);
    wait_out(BLANK, "second load");
    chk_slot("second load digit0", 8'h6D, 4'h1);

    // Reset pulsed in the digit2 slot: dark next cycle, then a fresh scan from digit 0.
    wait_phase(2 * DIV + 2);
    rst = 1'b1;
    @(negedge clk);
    chk_slot("mid-frame reset", 8'h00, 4'h0);
    rst = 1'b0;
    wait_out(BLANK, "post reset");
    chk_slot("post reset digit0", 8'h3F, 4'h1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      value = rand_value();
      dp = 4'($urandom);
      blank = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      lz = 1'($urandom);
      load = ($urandom % 5 == 0);
      rst = ($urandom % 150 == 0);
    end
    @(negedge clk);
    load = 1'b0;
    rst = 1'b0;
    repeat (2 * PER) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led7seg_scan.md
Name: led7seg_scan

Overview:
- Four-digit time-multiplexed driver for the board's 7-segment display.
- Accepts a 16-bit hex value plus per-digit decimal-point and blank masks through a load strobe.
- Scans the digits round-robin and drives registered segment (LED) and digit-select (SA) outputs.
- Updates are tear-free (frame-aligned) and each digit slot starts with a short anti-ghosting blank.

Parameters:
- DIV, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1: cycles at the start of each slot with outputs forced off; must be < DIV.
- ACTIVE_LOW, 0: if 1, invert both LED and SA at the output register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- value  in  16  hex digits; digit0 = value[3:0], digit3 = value[15:12].
- dp  in  4  decimal-point enable per digit (bit i = digit i).
- blank  in  4  force digit i dark.
- lz_suppress  in  1  leading-zero suppression enable.
- load  in  1  capture value/dp/blank/lz_suppress into the pending register.
- LED  out  8  segments; [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g, [7]=dp.
- SA  out  4  one-hot digit select; bit i = digit i.
- frame_tick  out  1  1-cycle pulse on the last cycle of a frame.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state is updated on the rising edge of clk.
- Reset clears: prescaler cnt=0, digit index dig=0, pending and active registers to 0.
  - Outputs at reset: LED=8'h00, SA=4'h0, frame_tick=0.
  - With ACTIVE_LOW=1: LED=8'hFF, SA=4'hF.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - On wrap, dig increments mod 4 (3 -> 0).
- frame_tick = (cnt==DIV-1 && dig==3). It is combinational from registers.
- Load and display-register update:
  - load=1 captures all inputs into pending; multiple loads in one frame: the last wins.
  - On the frame_tick edge, active <= pending. If load coincides with frame_tick, active <= the inputs directly, and pending takes them as well.
  - The display never shows a mix of old and new data within a frame.
- Output register: LED/SA are computed from the current cnt/dig/active and registered, so they lag the state by exactly 1 cycle.
- Slot gating. Dark means LED=0 and SA=0. A slot is dark when:
  - cnt < BLANK_CYCLES (anti-ghosting), or
  - blank[dig]=1, or
  - the digit is suppressed.
  - Otherwise: SA = 1<<dig, LED[6:0] = font(nibble), LED[7] = dp[dig].
- Leading-zero suppression: when lz_suppress=1, digit i (i = 3..1) is suppressed if it and every higher digit are 0. Digit 0 is never suppressed.
  - A suppressed digit is fully dark, including dp.
- Font, 7-bit {g,f,e,d,c,b,a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Reset mid-frame: outputs go dark on the next edge. Scan restarts at digit 0, cnt 0; active and pending clear.
- No other input combination stalls the scan; the scan period is always 4*DIV cycles.

Decomposition:
- Package led7seg_pkg:
  - segment bit-index constants SEG_A..SEG_G, SEG_DP;
  - NUM_DIGITS=4;
  - the 16-entry font constant table.
- One combinational sub-module seg_font: 4-bit nibble -> 7-bit pattern, used by led7seg_scan.

Test Plan (DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=0 unless stated):
- Reset then release, no load:
  - SA sequence from release: 0000, 0000, then 0001 x3, 0000, 0010 x3, 0000, 0100 x3, 0000, 1000 x3.
  - Every lit slot has LED=8'h3F.
  - frame_tick is high exactly once every 16 cycles.
- load with value=16'h12AF in the middle of the digit1 slot:
  - The current frame still shows 3F.
  - The next frame shows digit0=71, digit1=77, digit2=5B, digit3=06.
- lz_suppress=1:
  - value=16'h0050 -> digit3 and digit2 dark (SA=0), digit1=6D, digit0=3F.
  - value=16'h0000 -> only digit0 lit, LED=3F.
- value=16'h8888, dp=4'b0100, blank=4'b0001:
  - Digit0 slot fully dark (SA=0000, LED=00).
  - Digit2 LED=8'hFF; digits 1 and 3 LED=8'h7F.
- load asserted in the same cycle as frame_tick (value=16'h4321):
  - The following frame shows 4321 immediately.
  - A second load (16'h5555) two cycles later appears one frame after that.
- rst pulsed during the digit2 slot: next cycle LED=00, SA=0000, then the reset SA sequence restarts and shows 3F.
  - Repeat with ACTIVE_LOW=1: reset gives LED=FF, SA=F, and lit digit0 shows LED=8'hC0, SA=4'b1110.
